// File: rtl/disp_demux.sv
// Receive side of an 8-digit multiplexed seven-segment bus: synchronizes an/sseg,
// waits for a stable sample window, and rebuilds the per-digit segment bytes.
module disp_demux #(
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT_W     = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic [7:0] an,
  input  logic [7:0] sseg,
  output logic [7:0] out0,
  output logic [7:0] out1,
  output logic [7:0] out2,
  output logic [7:0] out3,
  output logic [7:0] out4,
  output logic [7:0] out5,
  output logic [7:0] out6,
  output logic [7:0] out7,
  output logic [7:0] dig_valid,
  output logic       frame_done,
  output logic       err_multi,
  output logic       timeout
);

  localparam int CW = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CAP_AT  = CW'(STABLE_CYCLES - 1);

  logic [15:0]          sync1;
  logic [15:0]          sync2;
  logic [15:0]          prev;
  logic [CW-1:0]        cnt;
  logic [7:0]           digits [8];
  logic [7:0]           seen;
  logic [TIMEOUT_W-1:0] tcnt;

  logic       capture;
  logic       single;
  logic       multi;
  logic [7:0] zeros;
  logic [7:0] seen_next;

  always_comb begin
    capture   = (sync2 == prev) && (cnt == CAP_AT);
    zeros     = ~sync2[15:8];
    single    = capture && (zeros != 8'h00) && ((zeros & (zeros - 8'd1)) == 8'h00);
    multi     = capture && ((zeros & (zeros - 8'd1)) != 8'h00);
    seen_next = seen | zeros;
  end

  // Reset state looks like "all anodes off, window just restarted".
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 16'hFFFF;
      sync2 <= 16'hFFFF;
      prev  <= 16'hFFFF;
      cnt   <= '0;
    end else begin
      sync1 <= {an, sseg};
      sync2 <= sync1;
      prev  <= sync2;
      if (sync2 != prev)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + 1'b1;
    end
  end

  // Segment data is written even when clear suppresses the status update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++)
        digits[i] <= 8'hFF;
    end else begin
      for (int i = 0; i < 8; i++)
        if (single && zeros[i])
          digits[i] <= sync2[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dig_valid  <= 8'h00;
      seen       <= 8'h00;
      frame_done <= 1'b0;
      err_multi  <= 1'b0;
      tcnt       <= '0;
    end else begin
      frame_done <= 1'b0;
      if (clear) begin
        dig_valid <= 8'h00;
        seen      <= 8'h00;
        err_multi <= 1'b0;
        tcnt      <= '0;
      end else begin
        if (multi)
          err_multi <= 1'b1;
        if (single) begin
          dig_valid <= dig_valid | zeros;
          tcnt      <= '0;
          if (seen_next == 8'hFF) begin
            frame_done <= 1'b1;
            seen       <= 8'h00;
          end else begin
            seen <= seen_next;
          end
        end else if (tcnt != '1) begin
          tcnt <= tcnt + 1'b1;
        end
      end
    end
  end

  assign timeout = (tcnt == '1);

  assign out0 = digits[0];
  assign out1 = digits[1];
  assign out2 = digits[2];
  assign out3 = digits[3];
  assign out4 = digits[4];
  assign out5 = digits[5];
  assign out6 = digits[6];
  assign out7 = digits[7];

endmodule

// File: doc/disp_demux.md
Name: disp_demux

Overview:
- Receive end of the time-multiplexed 8-digit seven-segment interface: samples active-low one-hot anode enables `an` and segment bus `sseg` and rebuilds the eight per-digit segment bytes.
- Used for board loopback and self-check, capturing display traffic from an external or on-chip multiplexed driver.
- Inputs are asynchronous to `clk`. They are synchronized and must be stable for a set number of samples before capture, which rejects transition glitches and ghosting.

Parameters:
- STABLE_CYCLES, 4: consecutive identical synchronized samples required before capture; must be >= 1.
- TIMEOUT_W, 20: width of the no-capture timeout counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear of status and frame tracking.
- an  in  8  anode enables, active-low, asynchronous.
- sseg  in  8  segment bus, asynchronous.
- out0..out7  out  8 each  captured segment byte per digit.
- dig_valid  out  8  bit i set once digit i has been captured since reset or clear.
- frame_done  out  1  one-cycle pulse when all 8 digits have been captured since the last pulse.
- err_multi  out  1  sticky; a stable sample had more than one anode low.
- timeout  out  1  no capture for 2^TIMEOUT_W-1 cycles.

Behaviour:
- Reset (rst=0, asynchronous), all registers:
  - out0..out7 = 8'hFF; dig_valid = 0; seen = 0; frame_done = 0; err_multi = 0; timeout counter = 0.
  - Both sync stages and prev = 16'hFFFF (all anodes inactive); stability count = 0.
- Synchronizer: 2-flop on {an, sseg}. samp = second-stage value.
- Stability, at every edge:
  - prev <= samp.
  - If samp != prev, cnt <= 0.
  - Else if cnt != STABLE_CYCLES, cnt <= cnt+1 (saturates).
- Capture event: the edge where samp == prev and cnt == STABLE_CYCLES-1.
  - Exactly one capture per stable period; no re-capture until samp changes.
- Latency: an input value present at edge 0 and held is written to the output at edge 2+STABLE_CYCLES. With the default, outputs update after edge 6.
- Any input change within the window restarts the count; shorter pulses are never captured.
- Anode decode on a capture event:
  - Exactly one zero bit i: out_i <= sseg; dig_valid[i] <= 1; seen[i] <= 1; timeout counter <= 0.
  - All ones (blank): no write, no error, timeout counter keeps running.
  - Two or more zeros: err_multi <= 1 (sticky), no write.
- Frame tracking:
  - seen_next = seen | onehot(i).
  - If seen_next == 8'hFF: frame_done <= 1 for one cycle and seen <= 0 at the same edge.
  - Re-capturing an already-seen digit does not advance the frame.
- Timeout:
  - Counter increments each cycle without a successful single-anode capture and saturates at all ones.
  - timeout = (counter == all ones).
  - It deasserts at the edge of the next successful capture.
- clear=1:
  - Next edge: dig_valid, seen, err_multi, and the timeout counter go to 0; frame_done = 0.
  - out0..out7 are retained. Synchronizer and stability state are unaffected.
  - clear has priority over a capture in the same cycle: the capture's data still writes out_i, but dig_valid, seen and frame_done do not update.
- Reset mid-stream: the stability window restarts after reset release, and the first capture occurs no earlier than edge 2+STABLE_CYCLES after release.
- Segment polarity is passed through unmodified; no decoding is done.

Test Plan:
- Reset: rst=0 while inputs toggle → out0..out7 = FF, dig_valid = 00, frame_done = err_multi = timeout = 0. After release, no capture before edge 6.
- Single digit: an=FE, sseg=C0 held 10 cycles (STABLE_CYCLES=4) → out0 = C0 after edge 6, dig_valid = 01, no other out changes. Exactly one capture (check with the timeout counter reset).
- Glitch reject: an=FD, sseg=A4 held 3 cycles, then back to FE/C0 → out1 stays FF, dig_valid[1] = 0.
- Full frame: digits 0..7 with sseg = 8'h10+i, each held 8 cycles → outi = 10+i.
  - frame_done pulses one cycle at digit 7's capture edge; dig_valid = FF.
  - Repeating the frame gives a second single pulse.
  - Repeating digit 3 mid-frame does not pulse early.
- Multi-anode: an=FC held 8 cycles → err_multi = 1, out0/out1 unchanged.
  - Later valid captures keep err_multi = 1.
  - clear=1 for one cycle → err_multi = 0, dig_valid = 00, outs retained.
- Timeout (TIMEOUT_W=4): capture digit 0, then hold an=FF → timeout = 1 at 15 cycles after the capture edge. Capturing an=F7 deasserts it at that capture edge.
